// File: rtl/lsq_port_op_if.sv
// ============================================================================
// Module  : lsq_port_op_if
// Brief   : Address/data handshake bundle between circuit, port adapter and LSQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsq_port_op_if #(
  parameter int ADDRESS_SIZE    = 32,
  parameter int DATA_SIZE       = 32,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int C_OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDRESS_SIZE-1:0] addr_in;
  logic                    addr_in_valid;
  logic                    addr_in_ready;
  logic [DATA_SIZE-1:0]    data_in;
  logic                    data_in_valid;
  logic                    data_in_ready;
  logic [ADDRESS_SIZE-1:0] addr_out;
  logic                    addr_out_valid;
  logic                    addr_out_ready;
  logic [DATA_SIZE-1:0]    data_out;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic [C_OUT_W-1:0]      outstanding;

  // Adapter side.
  modport slave (
    input  addr_in, addr_in_valid, data_in, data_in_valid,
    input  addr_out_ready, data_out_ready,
    output addr_in_ready, data_in_ready,
    output addr_out, addr_out_valid, data_out, data_out_valid, outstanding
  );

  // Driving side (circuit / LSQ models).
  modport master (
    output addr_in, addr_in_valid, data_in, data_in_valid,
    output addr_out_ready, data_out_ready,
    input  addr_in_ready, data_in_ready,
    input  addr_out, addr_out_valid, data_out, data_out_valid, outstanding
  );
endinterface

`default_nettype wire

// File: rtl/lsq_port_op.sv
// ============================================================================
// Module  : lsq_port_op
// Brief   : LSQ load/store port adapter with a DEPTH-entry FIFO per channel.
//           Macro LSQ_PORT_BYPASS_EN enables 0-cycle bypass through empty FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsq_port_op_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int                 C_PTR_W    = $clog2(DEPTH);
  localparam int                 C_CNT_W    = $clog2(DEPTH + 1);
  localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(DEPTH - 1);
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == C_FULL_CNT);
  // A pop while empty only happens on bypass: the pushed word leaves directly.
  assign w_wr  = push && !(pop && empty);
  assign w_rd  = pop && !empty;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + C_PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module lsq_port_op #(
  parameter int IS_STORE        = 0,
  parameter int DATA_SIZE       = 32,
  parameter int ADDRESS_SIZE    = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic          clk,
  input logic          rst,
  lsq_port_op_if.slave bus
);
  localparam int                 C_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [C_OUT_W-1:0] C_MAX   = C_OUT_W'(MAX_OUTSTANDING);
`ifdef LSQ_PORT_BYPASS_EN
  localparam logic               C_BYPASS = 1'b1;
`else
  localparam logic               C_BYPASS = 1'b0;
`endif

  logic                    w_a_push;
  logic                    w_a_pop;
  logic                    w_a_empty;
  logic                    w_a_full;
  logic                    w_a_avail;
  logic [ADDRESS_SIZE-1:0] w_a_head;
  logic                    w_d_push;
  logic                    w_d_pop;
  logic                    w_d_empty;
  logic                    w_d_full;
  logic                    w_d_avail;
  logic [DATA_SIZE-1:0]    w_d_head;

  lsq_port_op_fifo #(.WIDTH(ADDRESS_SIZE), .DEPTH(DEPTH)) u_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_a_push),
    .wr_data (bus.addr_in),
    .pop     (w_a_pop),
    .head    (w_a_head),
    .empty   (w_a_empty),
    .full    (w_a_full)
  );

  lsq_port_op_fifo #(.WIDTH(DATA_SIZE), .DEPTH(DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_d_push),
    .wr_data (bus.data_in),
    .pop     (w_d_pop),
    .head    (w_d_head),
    .empty   (w_d_empty),
    .full    (w_d_full)
  );

  assign bus.addr_in_ready = !rst && !w_a_full;
  assign w_a_push          = bus.addr_in_valid && bus.addr_in_ready;
  assign w_d_push          = bus.data_in_valid && bus.data_in_ready;

  // A channel can present a word if it holds one, or (bypass) one is arriving now.
  assign w_a_avail = !w_a_empty || (C_BYPASS && w_a_push);
  assign w_d_avail = !w_d_empty || (C_BYPASS && w_d_push);

  assign bus.addr_out = (C_BYPASS && w_a_empty && w_a_push) ? bus.addr_in : w_a_head;
  assign bus.data_out = (C_BYPASS && w_d_empty && w_d_push) ? bus.data_in : w_d_head;

  if (IS_STORE == 0) begin : g_load
    logic [C_OUT_W-1:0] r_outstanding;
    logic               w_below_cap;

    assign w_below_cap        = (r_outstanding < C_MAX);
    assign bus.addr_out_valid = !rst && w_a_avail && w_below_cap;
    assign bus.data_out_valid = !rst && w_d_avail;
    // A result is only accepted against an address already issued.
    assign bus.data_in_ready  = !rst && !w_d_full && (r_outstanding != '0);
    assign w_a_pop            = bus.addr_out_valid && bus.addr_out_ready;
    assign w_d_pop            = bus.data_out_valid && bus.data_out_ready;
    assign bus.outstanding    = r_outstanding;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_outstanding <= '0;
      end else if (w_a_pop && !w_d_push) begin
        r_outstanding <= r_outstanding + C_OUT_W'(1);
      end else if (!w_a_pop && w_d_push) begin
        r_outstanding <= r_outstanding - C_OUT_W'(1);
      end
    end
  end else begin : g_store
    logic w_pair_valid;
    logic w_unused;

    // Address and data leave together; FIFO order keeps the k-th of each paired.
    assign w_pair_valid       = !rst && w_a_avail && w_d_avail;
    assign bus.addr_out_valid = w_pair_valid;
    assign bus.data_out_valid = w_pair_valid;
    assign bus.data_in_ready  = !rst && !w_d_full;
    assign w_a_pop            = w_pair_valid && bus.addr_out_ready;
    assign w_d_pop            = w_a_pop;
    assign bus.outstanding    = '0;
    assign w_unused           = bus.data_out_ready;
  end
endmodule

`default_nettype wire

// File: tb/tb_lsq_port_op.sv
// Directed bench for lsq_port_op: a load port (MAX_OUTSTANDING=2) and a store port
// (10-bit address) side by side, with queue scoreboards checked on every output transfer.
`default_nettype none

module tb_lsq_port_op;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors  = 0;
  int errors   = 0;
  int l_issued = 0;
  int s_pairs  = 0;

  logic [31:0] q_laddr [$];
  logic [31:0] q_ldata [$];
  logic [9:0]  q_saddr [$];
  logic [31:0] q_sdata [$];

  lsq_port_op_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .MAX_OUTSTANDING(2)) lif ();
  lsq_port_op_if #(.ADDRESS_SIZE(10), .DATA_SIZE(32), .MAX_OUTSTANDING(8)) sif ();

  lsq_port_op #(.IS_STORE(0), .DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(4),
                .MAX_OUTSTANDING(2)) u_load (.clk(clk), .rst(rst), .bus(lif.slave));
  lsq_port_op #(.IS_STORE(1), .DATA_SIZE(32), .ADDRESS_SIZE(10), .DEPTH(4),
                .MAX_OUTSTANDING(8)) u_store (.clk(clk), .rst(rst), .bus(sif.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Output-side scoreboard: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (lif.addr_out_valid && lif.addr_out_ready) begin
      if (q_laddr.size() == 0) chk("l_addr_unexpected", 64'(lif.addr_out_valid), 64'(0));
      else chk("l_addr_order", 64'(lif.addr_out), 64'(q_laddr.pop_front()));
      l_issued++;
    end
    if (lif.data_out_valid && lif.data_out_ready) begin
      if (q_ldata.size() == 0) chk("l_data_unexpected", 64'(lif.data_out_valid), 64'(0));
      else chk("l_data_order", 64'(lif.data_out), 64'(q_ldata.pop_front()));
    end
    if (sif.addr_out_valid && sif.addr_out_ready) begin
      chk("s_pair_dvalid", 64'(sif.data_out_valid), 64'(1));
      if (q_saddr.size() == 0 || q_sdata.size() == 0) begin
        chk("s_pair_unexpected", 64'(sif.addr_out_valid), 64'(0));
      end else begin
        chk("s_pair_addr", 64'(sif.addr_out), 64'(q_saddr.pop_front()));
        chk("s_pair_data", 64'(sif.data_out), 64'(q_sdata.pop_front()));
      end
      s_pairs++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] la [3];
    la = '{32'h10, 32'h14, 32'h18};

    // ---------------- reset held two cycles with address valid high
    rst = 1'b1;
    lif.addr_in = 32'h99; lif.addr_in_valid = 1'b1; lif.data_in = '0; lif.data_in_valid = 1'b0;
    lif.addr_out_ready = 1'b1; lif.data_out_ready = 1'b1;
    sif.addr_in = 10'h55; sif.addr_in_valid = 1'b1; sif.data_in = '0; sif.data_in_valid = 1'b0;
    sif.addr_out_ready = 1'b0; sif.data_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_l_ain_ready", 64'(lif.addr_in_ready), 64'(0));
      chk("rst_s_ain_ready", 64'(sif.addr_in_ready), 64'(0));
      chk("rst_l_aout_valid", 64'(lif.addr_out_valid), 64'(0));
      chk("rst_l_dout_valid", 64'(lif.data_out_valid), 64'(0));
      chk("rst_s_aout_valid", 64'(sif.addr_out_valid), 64'(0));
      chk("rst_l_outstanding", 64'(lif.outstanding), 64'(0));
      chk("rst_l_addr_out", 64'(lif.addr_out), 64'(0));
      chk("rst_s_data_out", 64'(sif.data_out), 64'(0));
    end
    rst = 1'b0; lif.addr_in_valid = 1'b0; sif.addr_in_valid = 1'b0;
    #1;
    chk("post_rst_l_ain_ready", 64'(lif.addr_in_ready), 64'(1));
    chk("post_rst_s_ain_ready", 64'(sif.addr_in_ready), 64'(1));
    chk("post_rst_l_din_ready", 64'(lif.data_in_ready), 64'(0));

    // ---------------- load throttle at MAX_OUTSTANDING=2
    for (int i = 0; i < 3; i++) begin
      lif.addr_in = la[i]; lif.addr_in_valid = 1'b1; q_laddr.push_back(la[i]);
      tick();
    end
    lif.addr_in_valid = 1'b0;
    chk("thr_outstanding", 64'(lif.outstanding), 64'(2));
    chk("thr_aout_valid", 64'(lif.addr_out_valid), 64'(0));
    chk("thr_head_held", 64'(lif.addr_out), 64'(32'h18));
    chk("thr_issued", 64'(l_issued), 64'(2));
    tick(); tick();
    chk("thr_still_held", 64'(lif.addr_out_valid), 64'(0));
    lif.data_in = 32'hAA; lif.data_in_valid = 1'b1; q_ldata.push_back(32'hAA);
    #1;
    chk("ret_din_ready", 64'(lif.data_in_ready), 64'(1));
    tick();
    lif.data_in_valid = 1'b0;
    chk("ret_outstanding", 64'(lif.outstanding), 64'(1));
    chk("ret_aout_valid", 64'(lif.addr_out_valid), 64'(1));
    chk("ret_aout", 64'(lif.addr_out), 64'(32'h18));
    tick();
    chk("reissue_outstanding", 64'(lif.outstanding), 64'(2));
    chk("reissue_issued", 64'(l_issued), 64'(3));

    // ---------------- same-cycle issue and return at outstanding=1
    lif.data_in = 32'hBB; lif.data_in_valid = 1'b1; q_ldata.push_back(32'hBB);
    lif.addr_in = 32'h20; lif.addr_in_valid = 1'b1; q_laddr.push_back(32'h20);
    tick();
    lif.addr_in_valid = 1'b0;
    lif.data_in = 32'hCC; q_ldata.push_back(32'hCC);
    #1;
    chk("sim_pre_outstanding", 64'(lif.outstanding), 64'(1));
    chk("sim_pre_aout_valid", 64'(lif.addr_out_valid), 64'(1));
    tick();
    chk("sim_outstanding", 64'(lif.outstanding), 64'(1));
    lif.data_in = 32'hDD; q_ldata.push_back(32'hDD);
    tick();
    lif.data_in_valid = 1'b0;
    chk("drain_outstanding", 64'(lif.outstanding), 64'(0));
    lif.data_in = 32'hEE; lif.data_in_valid = 1'b1;
    #1;
    chk("orphan_din_ready", 64'(lif.data_in_ready), 64'(0));
    tick(); tick();
    lif.data_in_valid = 1'b0;
    chk("orphan_not_stored", 64'(lif.data_out_valid), 64'(0));
    chk("l_data_q_drained", 64'(q_ldata.size()), 64'(0));

    // ---------------- store join: address cycle 0, data cycle 3
    sif.addr_in = 10'h3F0; sif.addr_in_valid = 1'b1; q_saddr.push_back(10'h3F0);
    tick();
    sif.addr_in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("join_wait_valid", 64'(sif.addr_out_valid), 64'(0));
      if (i < 3) tick();
    end
    sif.data_in = 32'hDEADBEEF; sif.data_in_valid = 1'b1; q_sdata.push_back(32'hDEADBEEF);
    tick();
    sif.data_in_valid = 1'b0;
    chk("join_aout_valid", 64'(sif.addr_out_valid), 64'(1));
    chk("join_dout_valid", 64'(sif.data_out_valid), 64'(1));
    chk("join_aout", 64'(sif.addr_out), 64'(10'h3F0));
    chk("join_dout", 64'(sif.data_out), 64'(32'hDEADBEEF));
    chk("join_outstanding", 64'(sif.outstanding), 64'(0));
    sif.addr_out_ready = 1'b1;
    tick();
    sif.addr_out_ready = 1'b0;
    chk("join_popped", 64'(sif.addr_out_valid), 64'(0));
    chk("join_pairs", 64'(s_pairs), 64'(1));

    // ---------------- full FIFO and refused push during pop
    for (int k = 1; k <= 4; k++) begin
      sif.data_in = 32'h100 + 32'(k); sif.data_in_valid = 1'b1; q_sdata.push_back(32'h100 + 32'(k));
      tick();
    end
    sif.data_in = 32'h105;
    #1;
    chk("full_din_ready", 64'(sif.data_in_ready), 64'(0));
    sif.addr_in = 10'h001; sif.addr_in_valid = 1'b1; q_saddr.push_back(10'h001);
    tick();
    sif.addr_in_valid = 1'b0; sif.addr_out_ready = 1'b1;
    #1;
    chk("full_pushpop_ready", 64'(sif.data_in_ready), 64'(0));
    tick();
    sif.data_in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      sif.addr_in = 10'(k); sif.addr_in_valid = 1'b1; q_saddr.push_back(10'(k));
      tick();
    end
    sif.addr_in_valid = 1'b0;
    tick();
    chk("full_drained", 64'(sif.data_out_valid), 64'(0));
    chk("full_pairs", 64'(s_pairs), 64'(5));

    // ---------------- stream 1..10 across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      sif.addr_in = 10'(k + 32); sif.data_in = 32'(k);
      sif.addr_in_valid = 1'b1; sif.data_in_valid = 1'b1;
      q_saddr.push_back(10'(k + 32)); q_sdata.push_back(32'(k));
      tick();
    end
    sif.addr_in_valid = 1'b0; sif.data_in_valid = 1'b0;
    tick(); tick();
    chk("stream_pairs", 64'(s_pairs), 64'(15));
    chk("stream_q_empty", 64'(q_sdata.size()), 64'(0));
    sif.addr_out_ready = 1'b0;

    // ---------------- reset mid-run with buffered entries
    lif.data_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lif.addr_in = 32'h30 + 32'(4 * k); lif.addr_in_valid = 1'b1; q_laddr.push_back(32'h30 + 32'(4 * k));
      tick();
    end
    lif.addr_in_valid = 1'b0;
    sif.addr_in = 10'h077; sif.addr_in_valid = 1'b1;
    tick();
    sif.addr_in_valid = 1'b0;
    chk("mid_outstanding", 64'(lif.outstanding), 64'(2));
    chk("mid_issued", 64'(l_issued), 64'(6));
    rst = 1'b1;
    q_laddr.delete(); q_ldata.delete(); q_saddr.delete(); q_sdata.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_l_aout_valid", 64'(lif.addr_out_valid), 64'(0));
    chk("mid_rst_l_dout_valid", 64'(lif.data_out_valid), 64'(0));
    chk("mid_rst_s_aout_valid", 64'(sif.addr_out_valid), 64'(0));
    chk("mid_rst_outstanding", 64'(lif.outstanding), 64'(0));
    chk("mid_rst_addr_out", 64'(lif.addr_out), 64'(0));
    lif.data_out_ready = 1'b1; sif.addr_out_ready = 1'b1;
    sif.data_in = 32'h1234; sif.data_in_valid = 1'b1; q_sdata.push_back(32'h1234);
    sif.addr_in = 10'h02A; sif.addr_in_valid = 1'b1; q_saddr.push_back(10'h02A);
    tick();
    sif.data_in_valid = 1'b0; sif.addr_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_no_stale_issue", 64'(l_issued), 64'(6));
    chk("mid_fresh_pair", 64'(s_pairs), 64'(16));
    chk("mid_final_outstanding", 64'(lif.outstanding), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

`default_nettype wire
